// File: rtl/regfile_dump_reader.sv
// Read-side dump sequencer for the 32x32 register file: walks an index range on
// the asynchronous read port and streams (index, data) beats over valid/ready.
module regfile_dump_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_idx;

    // Index advance wraps modulo NUM_REGS even when NUM_REGS is not a power of two.
    function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] nxt;
        if (idx == ADDR_W'(NUM_REGS - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + ADDR_W'(1);
        end
        return nxt;
    endfunction

    // Dump sequencer: state, range bookkeeping and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            end_idx   <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            // A handshake in this same cycle has already been seen by the consumer.
            state     <= IDLE;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        cur     <= first_reg;
                        end_idx <= last_reg;
                        rd_addr <= first_reg;
                        busy    <= 1'b1;
                        state   <= READ;
                    end else begin
                        rd_addr <= '0;
                        busy    <= 1'b0;
                    end
                end
                READ: begin
                    // rd_data reflects the file before this edge, so a same-edge write is not seen.
                    out_data  <= rd_data;
                    out_index <= cur;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (cur == end_idx) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur     <= next_index(cur);
                            rd_addr <= next_index(cur);
                            state   <= READ;
                        end
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    rd_addr <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    rd_addr   <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural 32x32 register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] regs [32];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int beat_cyc   = 0;
    int prev_cyc   = 0;

    regfile_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (we) regs[wa] <= wd;
    end

    assign rd_data = regs[rd_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        step();
        we = 1'b0;
    endtask

    task automatic kick(input logic [4:0] f, input logic [4:0] l);
        start = 1'b1; first_reg = f; last_reg = l;
        step();
        start = 1'b0;
    endtask

    // Waits (bounded) for a beat, checks it, then steps through the accepting edge.
    task automatic get_beat(input string tag, input logic [4:0] ei, input logic [31:0] ed);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        beat_cyc = cyc;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_idx"}, {27'd0, out_index}, {27'd0, ei});
        check({tag, "_data"}, out_data, ed);
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_reg = 5'd0; last_reg = 5'd0;
        abort = 1'b0; out_ready = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdaddr", {27'd0, rd_addr}, 32'd0);
        check("rst_data", out_data, 32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: basic three-register dump at full rate
        wr(5'd5, 32'h11); wr(5'd6, 32'h22); wr(5'd7, 32'h33);
        out_ready = 1'b1;
        kick(5'd5, 5'd7);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_rdaddr", {27'd0, rd_addr}, 32'd5);
        get_beat("t1_b0", 5'd5, 32'h11);
        prev_cyc = beat_cyc;
        get_beat("t1_b1", 5'd6, 32'h22);
        check("t1_gap1", beat_cyc - prev_cyc, 32'd2);
        prev_cyc = beat_cyc;
        get_beat("t1_b2", 5'd7, 32'h33);
        check("t1_gap2", beat_cyc - prev_cyc, 32'd2);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_done_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("t1_done_once", {31'd0, done}, 32'd0);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_rdaddr", {27'd0, rd_addr}, 32'd0);

        // 2: range wraps through 31 to 0
        wr(5'd30, 32'hA30); wr(5'd31, 32'hA31); wr(5'd0, 32'hA00); wr(5'd1, 32'hA01);
        kick(5'd30, 5'd1);
        get_beat("t2_b0", 5'd30, 32'hA30);
        get_beat("t2_b1", 5'd31, 32'hA31);
        get_beat("t2_b2", 5'd0, 32'hA00);
        get_beat("t2_b3", 5'd1, 32'hA01);
        check("t2_done", {31'd0, done}, 32'd1);
        step();

        // 3: backpressure holds the beat stable
        wr(5'd10, 32'hCAFE0010); wr(5'd11, 32'hCAFE0011);
        out_ready = 1'b0;
        kick(5'd10, 5'd11);
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("t3_hold%0d_idx", i), {27'd0, out_index}, 32'd10);
            check($sformatf("t3_hold%0d_data", i), out_data, 32'hCAFE0010);
            step();
        end
        out_ready = 1'b1;
        get_beat("t3_b0", 5'd10, 32'hCAFE0010);
        get_beat("t3_b1", 5'd11, 32'hCAFE0011);
        check("t3_done", {31'd0, done}, 32'd1);
        step();

        // 4: write to the register at its READ edge is not captured
        wr(5'd3, 32'h1234);
        kick(5'd3, 5'd3);
        check("t4_rdaddr", {27'd0, rd_addr}, 32'd3);
        we = 1'b1; wa = 5'd3; wd = 32'hBEEF;
        step();
        we = 1'b0;
        get_beat("t4_old", 5'd3, 32'h1234);
        step();
        kick(5'd3, 5'd3);
        get_beat("t4_new", 5'd3, 32'hBEEF);
        step();

        // 5: abort during the second beat of a 0..9 dump
        kick(5'd0, 5'd9);
        get_beat("t5_b0", 5'd0, 32'hA00);
        out_ready = 1'b0;
        step();
        check("t5_b1_idx", {27'd0, out_index}, 32'd1);
        check("t5_b1_valid", {31'd0, out_valid}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_valid", {31'd0, out_valid}, 32'd0);
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        check("t5_abort_done", {31'd0, done}, 32'd0);
        step();
        check("t5_nodone", {31'd0, done}, 32'd0);
        out_ready = 1'b1;
        kick(5'd0, 5'd0);
        get_beat("t5_single", 5'd0, 32'hA00);
        check("t5_single_done", {31'd0, done}, 32'd1);
        step();
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        // 6a: asynchronous reset in the middle of SEND
        out_ready = 1'b0;
        kick(5'd5, 5'd7);
        step();
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_idx", {27'd0, out_index}, 32'd0);
        check("t6_rst_data", out_data, 32'd0);
        check("t6_rst_rdaddr", {27'd0, rd_addr}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("t6_post_done", {31'd0, done}, 32'd0);
        check("t6_post_busy", {31'd0, busy}, 32'd0);

        // 6b: start while busy is ignored
        out_ready = 1'b1;
        kick(5'd5, 5'd7);
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd0;
        step();
        start = 1'b0;
        get_beat("t6_b0", 5'd5, 32'h11);
        start = 1'b1; first_reg = 5'd30; last_reg = 5'd31;
        step();
        start = 1'b0;
        get_beat("t6_b1", 5'd6, 32'h22);
        get_beat("t6_b2", 5'd7, 32'h33);
        check("t6_done", {31'd0, done}, 32'd1);
        step();
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        step();
        check("t6_no_restart", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
